// File: rtl/alu_defs.sv
`default_nettype none
// ============================================================================
// Package  : alu_defs
// Purpose  : Shared ALU op codes, FSM state encoding and sizing constants
//            for the two-requester ALU arbiter.
// Revision : 1.0  initial release
// ============================================================================
package alu_defs;

    // Op bit 3 inverts the left operand, bit 2 inverts the right operand
    // (and supplies the carry-in), bits [1:0] select AND/OR/ADD/SLT.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Exec wait counter covers ALU_LATENCY 0..7.
    localparam int CNT_W  = 3;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin picker. A sole requester wins outright; on a
//            tie the requester that did not win last time is chosen.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot winner selection; last_grant is the index of the previous winner.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu32b_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu32b_arbiter
// Purpose  : Shares one external combinational ALU between two requesters.
//            Round-robin grant, valid/ready handshakes on request and
//            response, one operation in flight, registered result.
//            Optional macro ALU_ARB_STATS_EN adds per-requester saturating
//            16-bit grant counters (grant_cnt0, grant_cnt1).
// Revision : 1.0  initial release
// ============================================================================
module alu32b_arbiter
    import alu_defs::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int OP_WIDTH    = 4,
    parameter int ALU_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic [OP_WIDTH-1:0]   alu_op,
    output logic [DATA_WIDTH-1:0] alu_left,
    output logic [DATA_WIDTH-1:0] alu_right,
    input  logic [DATA_WIDTH-1:0] alu_result
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     grant_cnt0,
    output logic [STAT_W-1:0]     grant_cnt1
`endif
);

    state_t                state_q,      state_d;
    logic [OP_WIDTH-1:0]   op_q,         op_d;
    logic [DATA_WIDTH-1:0] a_q,          a_d;
    logic [DATA_WIDTH-1:0] b_q,          b_d;
    logic [DATA_WIDTH-1:0] result_q,     result_d;
    logic                  owner_q,      owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;

    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_rsp_take;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (w_grant)
    );

    // Readies are gated by rst so every output reads 0 while reset is held.
    assign w_accept   = (state_q == ST_IDLE) && !rst && (w_grant != 2'b00);
    assign req0_ready = w_accept && w_grant[0];
    assign req1_ready = w_accept && w_grant[1];

    // ALU inputs come only from capture registers: no request-to-ALU path.
    assign alu_op    = op_q;
    assign alu_left  = a_q;
    assign alu_right = b_q;

    assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
    assign rsp0_result = rsp0_valid ? result_q : '0;
    assign rsp1_result = rsp1_valid ? result_q : '0;
    assign w_rsp_take  = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state logic: accept in IDLE, count down in EXEC, hand back in RESP.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    op_d         = w_grant[1] ? req1_op : req0_op;
                    a_d          = w_grant[1] ? req1_a  : req0_a;
                    b_d          = w_grant[1] ? req1_b  : req0_b;
                    owner_d      = w_grant[1];
                    last_grant_d = w_grant[1];
                    cnt_d        = CNT_W'(ALU_LATENCY);
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_result;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (w_rsp_take) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset favours requester 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [STAT_W-1:0] grant_cnt1_q, grant_cnt1_d;

    // Saturating per-requester grant counters.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (req0_ready && (grant_cnt0_q != {STAT_W{1'b1}})) begin
            grant_cnt0_d = grant_cnt0_q + 1'b1;
        end
        if (req1_ready && (grant_cnt1_q != {STAT_W{1'b1}})) begin
            grant_cnt1_d = grant_cnt1_q + 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
`default_nettype wire
